// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a show-ahead FIFO into back-to-back LSB-first frames.
// Optional parity bit and par_typ port are enabled by defining PARITY_EN.
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
`ifdef PARITY_EN
    input  logic                  par_typ,
`endif
    output logic                  tx_out,
    output logic                  busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  rinc_q, rinc_d;
`ifdef PARITY_EN
    logic                  par_q, par_d;
`endif

    logic                  baud_end;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] shift_nx;

    assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_bit = (bit_q == BIT_W'(DATA_WIDTH - 1));
    assign shift_nx = shift_q >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rinc_q  <= 1'b0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rinc_q  <= rinc_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // tx_d always carries the level of the bit period that the next state begins,
    // so the line changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rinc_d  = 1'b0;
`ifdef PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!rempty) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = rdata;
                    rinc_d  = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef PARITY_EN
                    par_d   = ^rdata;
`endif
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = shift_nx;
                    if (last_bit) begin
`ifdef PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q ^ par_typ;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = shift_nx[0];
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    // rempty is only looked at here, so a slow empty-flag update never double-pops
                    if (!rempty) begin
                        state_d = START;
                        shift_d = rdata;
                        rinc_d  = 1'b1;
                        tx_d    = 1'b0;
`ifdef PARITY_EN
                        par_d   = ^rdata;
`endif
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign rinc   = rinc_q;
    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule
